// File: rtl/avs_burst_pkg.sv
// Shared constants for the Avalon-MM burst slave memory: default widths,
// FSM state encodings and the wait-injection LFSR definition.
package avs_burst_pkg;

  localparam int unsigned ADDR_W_DEF         = 32;
  localparam int unsigned DATA_W_DEF         = 32;
  localparam int unsigned BE_W_DEF           = 4;
  localparam int unsigned BE_LOG2_DEF        = 2;
  localparam int unsigned BURST_COUNT_DEF    = 8;
  localparam int unsigned BURST_W_DEF        = 4;
  localparam int unsigned MEM_DEPTH_LOG2_DEF = 10;
  localparam int unsigned READ_LATENCY_DEF   = 2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;
  localparam logic [1:0] RD_DRAIN = 2'd3;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avs_burst_slave_mem_if.sv
// Avalon-MM burst bus between a burst master and avs_burst_slave_mem.
interface avs_burst_slave_mem_if
  import avs_burst_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH        = DATA_W_DEF,
  parameter int unsigned BYTE_ENABLE_WIDTH = BE_W_DEF,
  parameter int unsigned BURST_WIDTH       = BURST_W_DEF
);

  logic [ADDRESS_WIDTH-1:0]     slave_address;
  logic                         slave_read;
  logic                         slave_write;
  logic [DATA_WIDTH-1:0]        slave_writedata;
  logic [BYTE_ENABLE_WIDTH-1:0] slave_byteenable;
  logic [BURST_WIDTH-1:0]       slave_burstcount;
  logic                         slave_waitrequest;
  logic                         slave_readdatavalid;
  logic [DATA_WIDTH-1:0]        slave_readdata;

  modport master (
    output slave_address, slave_read, slave_write, slave_writedata,
           slave_byteenable, slave_burstcount,
    input  slave_waitrequest, slave_readdatavalid, slave_readdata
  );

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata,
           slave_byteenable, slave_burstcount,
    output slave_waitrequest, slave_readdatavalid, slave_readdata
  );

endinterface

// File: rtl/avs_read_pipe.sv
// Fixed-latency read return pipe: READ_LATENCY stages of valid/data pairs.
// Data registers only load behind a valid beat, so the output holds its last beat.
module avs_read_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic                    empty_q, empty_d;

  // empty: nothing is queued behind the output stage
  always_comb begin
    empty_d = 1'b1;
    if (READ_LATENCY > 1) begin
      if (vld_i) empty_d = 1'b0;
      for (int unsigned i = 0; i + 2 < READ_LATENCY; i++) begin
        if (vld_q[i]) empty_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      empty_q <= 1'b1;
      for (int unsigned i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      empty_q  <= empty_d;
      vld_q[0] <= vld_i;
      if (vld_i) dat_q[0] <= data_i;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o   = vld_q[READ_LATENCY-1];
  assign data_o  = dat_q[READ_LATENCY-1];
  assign empty_o = empty_q;

endmodule

// File: rtl/avs_burst_slave_mem.sv
// Avalon-MM burst slave memory with byte-enabled writes and fixed-latency reads.
// Optional back-pressure injection: define AVS_WAIT_INJECT_EN.
module avs_burst_slave_mem
  import avs_burst_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH          = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH             = DATA_W_DEF,
  parameter int unsigned BYTE_ENABLE_WIDTH      = BE_W_DEF,
  parameter int unsigned BYTE_ENABLE_WIDTH_LOG2 = BE_LOG2_DEF,
  parameter int unsigned BURST_COUNT            = BURST_COUNT_DEF,
  parameter int unsigned BURST_WIDTH            = BURST_W_DEF,
  parameter int unsigned MEM_DEPTH_LOG2         = MEM_DEPTH_LOG2_DEF,
  parameter int unsigned READ_LATENCY           = READ_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  avs_burst_slave_mem_if.slave  bus,
  output logic                  protocol_error
);

  localparam int unsigned IDX_W = MEM_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic                   wait_q, wait_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   we_c;
  logic [IDX_W-1:0]       wr_idx_c;
  logic                   rd_issue_c;
  logic [DATA_WIDTH-1:0]  rd_data_c;
  logic [IDX_W-1:0]       cmd_idx_c;
  logic                   cnt_ok_c;
  logic                   stall_c;
  logic                   pipe_empty;
  logic                   unused_addr_c;

  assign cmd_idx_c     = bus.slave_address[BYTE_ENABLE_WIDTH_LOG2 +: IDX_W];
  assign cnt_ok_c      = (bus.slave_burstcount != '0) &&
                         (32'(bus.slave_burstcount) <= BURST_COUNT);
  assign rd_data_c     = mem_q[idx_q];
  assign unused_addr_c = ^bus.slave_address;

`ifdef AVS_WAIT_INJECT_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  // Looks one step ahead so the registered waitrequest tracks the current LFSR value
  assign stall_c = (lfsr_next(lfsr_q) & 8'h03) == 8'h00;
`else
  assign stall_c = 1'b0;
`endif

  // Next-state, address/count and write-enable decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    we_c       = 1'b0;
    wr_idx_c   = idx_q;
    rd_issue_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!wait_q) begin
          if (bus.slave_write) begin
            if (bus.slave_read) err_d = 1'b1;
            if (!cnt_ok_c) begin
              err_d = 1'b1;
            end else begin
              we_c     = 1'b1;
              wr_idx_c = cmd_idx_c;
              idx_d    = cmd_idx_c + IDX_W'(1);
              cnt_d    = bus.slave_burstcount - BURST_WIDTH'(1);
              if (bus.slave_burstcount != BURST_WIDTH'(1)) state_d = WR_BURST;
            end
          end else if (bus.slave_read) begin
            if (!cnt_ok_c) begin
              err_d = 1'b1;
            end else begin
              idx_d   = cmd_idx_c;
              cnt_d   = bus.slave_burstcount;
              state_d = RD_BURST;
            end
          end
        end
      end
      WR_BURST: begin
        if (bus.slave_read) err_d = 1'b1;
        if (bus.slave_write && !wait_q) begin
          we_c  = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q - BURST_WIDTH'(1);
          if (cnt_q == BURST_WIDTH'(1)) state_d = IDLE;
        end
      end
      RD_BURST: begin
        rd_issue_c = 1'b1;
        idx_d      = idx_q + IDX_W'(1);
        cnt_d      = cnt_q - BURST_WIDTH'(1);
        if (cnt_q == BURST_WIDTH'(1)) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (pipe_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wait_d = (state_d == RD_BURST) || (state_d == RD_DRAIN) || stall_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Memory survives reset; unselected byte lanes keep their contents
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int unsigned b = 0; b < BYTE_ENABLE_WIDTH; b++) begin
        if (bus.slave_byteenable[b]) mem_q[wr_idx_c][b*8 +: 8] <= bus.slave_writedata[b*8 +: 8];
      end
    end
  end

  avs_read_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .reset   (reset),
    .vld_i   (rd_issue_c),
    .data_i  (rd_data_c),
    .vld_o   (bus.slave_readdatavalid),
    .data_o  (bus.slave_readdata),
    .empty_o (pipe_empty)
  );

  assign bus.slave_waitrequest = wait_q;
  assign protocol_error        = err_q;

endmodule
